syscall_reader: RTL and testbench
=================================

SYSCALL_READER -- requirements
Module: syscall_reader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port sys, input, 1, syscall strobe from decode; level-sampled.
REQ-004 SHALL have port regv, input, 32, $v0 value, the syscall code.
REQ-005 SHALL have port rega, input, 32, $a0 value, buffer byte address.
REQ-006 SHALL have port regl, input, 32, $a1 value, read_string max length.
REQ-007 SHALL have port rx_data, input, 8, console character.
REQ-008 SHALL have port rx_valid, input, 1, rx_data valid.
REQ-009 SHALL have port rx_ready, output, 1, character consumed on rx_valid&&rx_ready.
REQ-010 SHALL have port stall, output, 1, freezes the pipeline while a read syscall is in service.
REQ-011 SHALL have port mem_we, output, 1, data-memory word write strobe.
REQ-012 SHALL have port mem_addr, output, 30, word address.
REQ-013 SHALL have port mem_wdata, output, 32, write word; byte k occupies bits [8k+7:8k].
REQ-014 SHALL have port res_we, output, 1, one-cycle $v0 writeback strobe.
REQ-015 SHALL have port res_data, output, 32, $v0 writeback value.

Function
REQ-016 SHALL use states IDLE, RD_INT, RD_STR, FLUSH, WB.
REQ-017 In IDLE with sys=1: regv=5 -> RD_INT; regv=8 -> RD_STR; any other code -> stay IDLE, stall=0.
REQ-018 stall SHALL be combinationally 1 in the accepting cycle and SHALL stay 1 until the cycle after the final mem_we or res_we.
REQ-019 rx_ready SHALL be 1 only in RD_INT and RD_STR.
REQ-020 RD_INT: leading '-' (0x2D) as the first character sets negate; each '0'-'9' updates acc = acc*10 + digit, modulo 2^32; other non-newline characters are ignored; 0x0A moves to WB.
REQ-021 WB: res_we=1 for exactly one cycle; res_data = negate ? -acc : acc; then IDLE.
REQ-022 RD_STR: word pointer = rega[31:2] (rega[1:0] ignored); characters pack into bytes 0..3; each filled word is written with mem_we one cycle and the pointer increments (30-bit wrap).
REQ-023 RD_STR: at most regl-1 characters are stored; 0x0A is stored and ends input; reaching regl-1 stored characters ends input without consuming further rx characters.
REQ-024 After input ends, FLUSH SHALL write a NUL byte after the last character, zero-fill the remaining bytes, and write the partial word; if the last word was full, it writes an all-zero word at the next address.
REQ-025 regl=1 SHALL write a single all-zero word; regl=0 (or regl bit 31 set) SHALL write nothing and end service after one cycle.
REQ-026 sys is ignored outside IDLE; a sys still held high on the return to IDLE SHALL NOT retrigger until sys has been observed low for at least one cycle.

Reset
REQ-027 On rst_n=0, the block SHALL enter IDLE immediately with rx_ready=0, stall=0, mem_we=0, mem_addr=0, mem_wdata=0, res_we=0, res_data=0; acc, negate, and byte index clear.
REQ-028 Reset mid-syscall SHALL abandon the syscall with no further writes; the partial word is discarded.

Configuration
REQ-029 When SYSCALL_READ_CHAR_EN is defined, regv=12 SHALL consume one character and return it via WB zero-extended in res_data.
REQ-030 When SYSCALL_READ_CHAR_EN is not defined, regv=12 SHALL be treated as an unknown code.

Structure
REQ-031 The shared package syscall_pkg SHALL hold the syscall codes (PRINT_INT=1, PRINT_STR=4, READ_INT=5, READ_STR=8, EXIT=10, READ_CHAR=12), ASCII_NL=8'h0A, ASCII_MINUS=8'h2D, and the state enum.
REQ-032 Byte packing, NUL/zero-fill, and pointer increment SHALL live in the sub-module word_packer.

Verification
REQ-033 Scenario: regv=5, rx "-123\n" -> one res_we, res_data=32'hFFFFFF85, stall drops the following cycle.
REQ-034 Scenario: regv=8, rega=32'h00100024, regl=16, rx "hi\n" -> one write at addr 30'h00040009, data 32'h000A6968.
REQ-035 Scenario: regv=8, regl=5, rx "abcdef\n" -> 32'h64636261 @p, then 32'h00000000 @p+1; 'e' never consumed (rx_ready=0).
REQ-036 Scenario: regv=8, regl=0 -> no mem_we, stall high for exactly one cycle.
REQ-037 Scenario: rst_n low after 2 characters of read_string -> no mem_we; next syscall behaves normally.
REQ-038 Scenario: sys held high through a read_int and rx_valid toggling -> exactly one service; with macro, regv=12, rx 'A' -> res_data=32'h41.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared syscall codes, ASCII constants and controller states for the console reader.
package syscall_pkg;

    localparam logic [31:0] PRINT_INT = 32'd1;
    localparam logic [31:0] PRINT_STR = 32'd4;
    localparam logic [31:0] READ_INT  = 32'd5;
    localparam logic [31:0] READ_STR  = 32'd8;
    localparam logic [31:0] EXIT      = 32'd10;
    localparam logic [31:0] READ_CHAR = 32'd12;

    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    typedef enum logic [2:0] {
        IDLE,
        RD_INT,
        RD_STR,
        FLUSH,
        WB
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs console bytes little-endian into 32-bit words and writes each full word,
// then on flush writes the NUL-terminated, zero-filled tail word.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] ptr_init,
    input  logic        push,
    input  logic [7:0]  data,
    input  logic        flush,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata
);

    logic [29:0] ptr;
    logic [23:0] lanes;
    logic [1:0]  idx;
    logic        word_full;

    // Unfilled lanes are kept at zero, so a flush only has to append the NUL in byte 3.
    always_comb begin
        word_full = push && (idx == 2'd3);
        mem_we    = word_full || flush;
        mem_addr  = ptr;
        mem_wdata = 32'h0;
        if (word_full) begin
            mem_wdata = {data, lanes};
        end else if (flush) begin
            mem_wdata = {8'h00, lanes};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= 30'h0;
            lanes <= 24'h0;
            idx   <= 2'd0;
        end else if (start) begin
            ptr   <= ptr_init;
            lanes <= 24'h0;
            idx   <= 2'd0;
        end else if (push) begin
            if (idx == 2'd3) begin
                ptr   <= ptr + 30'd1;
                lanes <= 24'h0;
                idx   <= 2'd0;
            end else begin
                case (idx)
                    2'd0:    lanes[7:0]   <= data;
                    2'd1:    lanes[15:8]  <= data;
                    default: lanes[23:16] <= data;
                endcase
                idx <= idx + 2'd1;
            end
        end else if (flush) begin
            lanes <= 24'h0;
            idx   <= 2'd0;
        end
    end

endmodule

// File: rtl/syscall_reader.sv
// Services read_int / read_string syscalls from the console, stalling the pipeline meanwhile.
// Optional read_char (code 12) is enabled by defining SYSCALL_READ_CHAR_EN.
module syscall_reader
    import syscall_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys,
    input  logic [31:0] regv,
    input  logic [31:0] rega,
    input  logic [31:0] regl,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        stall,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        res_we,
    output logic [31:0] res_data
);

    state_t      state, state_nxt;
    logic [31:0] acc;
    logic        negate, first, armed, char_mode;
    logic [30:0] remain;
    logic        take, accept, is_int, is_str, is_char;
    logic        pk_start, pk_push, pk_flush;
    logic        unused_bits;

    assign unused_bits = ^rega[1:0];
    assign take        = rx_valid && rx_ready;
    assign is_int      = (regv == READ_INT);
    assign is_str      = (regv == READ_STR);
`ifdef SYSCALL_READ_CHAR_EN
    assign is_char     = (regv == READ_CHAR);
`else
    assign is_char     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        rx_ready  = 1'b0;
        res_we    = 1'b0;
        res_data  = 32'h0;
        accept    = 1'b0;
        pk_start  = 1'b0;
        pk_push   = 1'b0;
        pk_flush  = 1'b0;
        case (state)
            IDLE: begin
                if (sys && armed && (is_int || is_str || is_char)) begin
                    accept = 1'b1;
                    stall  = 1'b1;
                    if (is_str) begin
                        pk_start = 1'b1;
                        // Zero or negative length: nothing to write, service is this cycle only.
                        if (regl[31] || (regl == 32'h0)) state_nxt = IDLE;
                        else                             state_nxt = RD_STR;
                    end else begin
                        state_nxt = RD_INT;
                    end
                end
            end
            RD_INT: begin
                stall    = 1'b1;
                rx_ready = 1'b1;
                if (take && (char_mode || (rx_data == ASCII_NL))) state_nxt = WB;
            end
            RD_STR: begin
                stall    = 1'b1;
                rx_ready = (remain != 31'd0);
                if (remain == 31'd0) begin
                    state_nxt = FLUSH;
                end else if (take) begin
                    pk_push = 1'b1;
                    if (rx_data == ASCII_NL) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                stall     = 1'b1;
                pk_flush  = 1'b1;
                state_nxt = IDLE;
            end
            WB: begin
                stall     = 1'b1;
                res_we    = 1'b1;
                res_data  = negate ? -acc : acc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b1;
            acc       <= 32'h0;
            negate    <= 1'b0;
            first     <= 1'b0;
            char_mode <= 1'b0;
            remain    <= 31'd0;
        end else begin
            state <= state_nxt;
            // A held sys must be seen low once before another service may start.
            if (accept)    armed <= 1'b0;
            else if (!sys) armed <= 1'b1;

            if (accept) begin
                acc       <= 32'h0;
                negate    <= 1'b0;
                first     <= 1'b1;
                char_mode <= is_char;
                remain    <= regl[30:0] - 31'd1;
            end else if ((state == RD_INT) && take) begin
                first <= 1'b0;
                if (char_mode) begin
                    acc <= {24'h0, rx_data};
                end else if ((rx_data == ASCII_MINUS) && first) begin
                    negate <= 1'b1;
                end else if ((rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
                    acc <= acc * 32'd10 + {28'h0, rx_data[3:0]};
                end
            end else if ((state == RD_STR) && take) begin
                remain <= remain - 31'd1;
            end
        end
    end

    word_packer u_word_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (pk_start),
        .ptr_init  (rega[31:2]),
        .push      (pk_push),
        .data      (rx_data),
        .flush     (pk_flush),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_syscall_reader.sv
// Self-checking bench for syscall_reader: directed scenarios plus randomized
// read_int / read_string traffic against a byte-level reference model.
module tb_syscall_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sys = 1'b0;
    logic [31:0] regv = 32'h0, rega = 32'h0, regl = 32'h0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, stall, mem_we, res_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, res_data;

    int tests = 0;
    int fails = 0;

    byte unsigned rx_q[$];
    logic [61:0]  got_w[$];
    logic [61:0]  exp_w[$];
    logic [31:0]  got_r[$];
    int           stall_cycles, last_write_cyc, done_cyc;

    always #5 clk = ~clk;

    syscall_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sys       (sys),
        .regv      (regv),
        .rega      (rega),
        .regl      (regl),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .stall     (stall),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .res_we    (res_we),
        .res_data  (res_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_res_we"}, 64'(res_we), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
    endtask

    task automatic load_str(input string s);
        rx_q.delete();
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    endtask

    // Value a console read_int returns for the characters currently queued.
    function automatic logic [31:0] model_int();
        logic [31:0] val = 32'h0;
        bit neg = (rx_q.size() > 0) && (rx_q[0] == 8'h2D);
        foreach (rx_q[i]) begin
            if (rx_q[i] == 8'h0A) break;
            if (rx_q[i] >= 8'h30 && rx_q[i] <= 8'h39) val = val * 32'd10 + 32'(rx_q[i] - 8'h30);
        end
        return neg ? (32'h0 - val) : val;
    endfunction

    // Memory image a read_string should produce: stored chars, NUL, zero pad to a word.
    task automatic model_str(input logic [31:0] a, input logic [31:0] l, output int consumed);
        byte unsigned b[$];
        int limit;
        exp_w.delete();
        consumed = 0;
        if (l == 0 || l[31]) return;
        limit = int'(l) - 1;
        foreach (rx_q[i]) begin
            if (consumed == limit) break;
            b.push_back(rx_q[i]);
            consumed++;
            if (rx_q[i] == 8'h0A) break;
        end
        b.push_back(8'h00);
        while (b.size() % 4 != 0) b.push_back(8'h00);
        for (int w = 0; w < b.size() / 4; w++)
            exp_w.push_back({30'(a[31:2] + 30'(w)), b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    endtask

    // Runs one syscall until stall falls; rx_valid is randomly throttled.
    task automatic service(input logic [31:0] v, input logic [31:0] a, input logic [31:0] l,
                           input bit hold, input string tag);
        bit hs, done;
        int viol;
        got_w.delete();
        got_r.delete();
        stall_cycles = 0; last_write_cyc = -1; done_cyc = -1; viol = 0; done = 0;
        sys = 1'b1; regv = v; rega = a; regl = l;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            rx_valid = (rx_q.size() > 0) && ($urandom_range(3) != 0);
            rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'($urandom);
            @(negedge clk);
            if (stall) stall_cycles++;
            if (rx_ready && !stall) viol++;
            if (mem_we) begin got_w.push_back({mem_addr, mem_wdata}); last_write_cyc = cyc; end
            if (res_we) begin got_r.push_back(res_data); last_write_cyc = cyc; end
            hs = rx_valid && rx_ready;
            if (!stall) begin done = 1; done_cyc = cyc; end
            @(posedge clk); #1;
            if (hs) void'(rx_q.pop_front());
            if (!hold) sys = 1'b0;
        end
        rx_valid = 1'b0;
        check({tag, "_finished"}, 64'(done), 64'd1);
        check({tag, "_ready_without_stall"}, 64'(viol), 64'd0);
    endtask

    task automatic run_int(input logic [31:0] a, input bit hold, input string tag);
        logic [31:0] exp = model_int();
        service(32'd5, a, 32'd3, hold, tag);
        check({tag, "_res_count"}, 64'(got_r.size()), 64'd1);
        check({tag, "_mem_count"}, 64'(got_w.size()), 64'd0);
        if (got_r.size() > 0) check({tag, "_res_data"}, 64'(got_r[0]), 64'(exp));
        check({tag, "_stall_drop"}, 64'(done_cyc), 64'(last_write_cyc + 1));
        check({tag, "_rx_left"}, 64'(rx_q.size()), 64'd0);
    endtask

    task automatic run_str(input logic [31:0] a, input logic [31:0] l, input string tag);
        int consumed, left;
        model_str(a, l, consumed);
        left = rx_q.size() - consumed;
        service(32'd8, a, l, 1'b0, tag);
        check({tag, "_mem_count"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
        check({tag, "_res_count"}, 64'(got_r.size()), 64'd0);
        check({tag, "_rx_left"}, 64'(rx_q.size()), 64'(left));
        if (exp_w.size() > 0) check({tag, "_stall_drop"}, 64'(done_cyc), 64'(last_write_cyc + 1));
        else                  check({tag, "_stall_one"}, 64'(stall_cycles), 64'd1);
    endtask

    task automatic idle_cycle();
        sys = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int hs_cnt, we_cnt, n;
        logic [31:0] a, l;
        bit hs;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_cycle();

        // read_int "-123\n"
        load_str("-123\n");
        run_int(32'h0, 1'b0, "int_neg123");
        check("int_neg123_const", 64'(got_r.size() > 0 ? got_r[0] : 32'h0), 64'hFFFFFF85);
        idle_cycle();

        // read_string "hi\n" at 0x00100024
        load_str("hi\n");
        run_str(32'h00100024, 32'd16, "str_hi");
        check("str_hi_const", 64'(got_w.size() > 0 ? got_w[0] : 62'h0), 64'({30'h00040009, 32'h000A6968}));
        idle_cycle();

        // length limit: 'e' must stay unconsumed
        load_str("abcdef\n");
        run_str(32'h00000200, 32'd5, "str_limit");
        check("str_limit_next_char", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h0), 64'h65);
        idle_cycle();

        load_str("xyz\n");
        run_str(32'h00000040, 32'd0, "str_len0");
        idle_cycle();
        load_str("xyz\n");
        run_str(32'h00000040, 32'd1, "str_len1");
        idle_cycle();
        load_str("abc\n");
        run_str(32'h00000080, 32'd10, "str_full_nl");
        idle_cycle();
        load_str("xyz\n");
        run_str(32'hFFFFFFFC, 32'd7, "str_wrap");
        idle_cycle();

        // unknown code: no stall, no service
        load_str("7\n");
        service(32'd1, 32'h0, 32'd4, 1'b0, "unknown");
        check("unknown_stall", 64'(stall_cycles), 64'd0);
        check("unknown_rx_left", 64'(rx_q.size()), 64'd2);
        idle_cycle();

`ifdef SYSCALL_READ_CHAR_EN
        load_str("A");
        service(32'd12, 32'h0, 32'd0, 1'b0, "read_char");
        check("read_char_res_count", 64'(got_r.size()), 64'd1);
        check("read_char_data", 64'(got_r.size() > 0 ? got_r[0] : 32'h0), 64'h41);
`else
        load_str("A");
        service(32'd12, 32'h0, 32'd0, 1'b0, "read_char_off");
        check("read_char_off_stall", 64'(stall_cycles), 64'd0);
        check("read_char_off_rx_left", 64'(rx_q.size()), 64'd1);
`endif
        idle_cycle();

        // sys held high through a read_int: exactly one service
        load_str("42\n");
        run_int(32'h0, 1'b1, "held");
        n = 0;
        for (int i = 0; i < 6; i++) begin
            rx_valid = $urandom_range(1);
            rx_data  = 8'h39;
            @(negedge clk);
            if (stall || res_we || mem_we) n++;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("held_no_retrigger", 64'(n), 64'd0);
        idle_cycle();

        // reset after two characters of a read_string
        load_str("abcde\n");
        sys = 1'b1; regv = 32'd8; rega = 32'h00000100; regl = 32'd16;
        hs_cnt = 0; we_cnt = 0;
        for (int cyc = 0; cyc < 20 && hs_cnt < 2; cyc++) begin
            rx_valid = 1'b1;
            rx_data  = rx_q[0];
            @(negedge clk);
            if (mem_we) we_cnt++;
            hs = rx_valid && rx_ready;
            @(posedge clk); #1;
            sys = 1'b0;
            if (hs) begin void'(rx_q.pop_front()); hs_cnt++; end
        end
        check("rst_mid_chars", 64'(hs_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
        end
        @(posedge clk); #1;
        check("rst_mid_no_write", 64'(we_cnt), 64'd0);
        load_str("hi\n");
        run_str(32'h00100024, 32'd16, "after_rst");
        idle_cycle();

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1) == 0) begin
                rx_q.delete();
                if ($urandom_range(1)) rx_q.push_back(8'h2D);
                n = $urandom_range(12);
                for (int i = 0; i < n; i++) begin
                    case ($urandom_range(9))
                        0:       rx_q.push_back(8'h78);
                        1:       rx_q.push_back(8'h2D);
                        default: rx_q.push_back(8'(8'h30 + $urandom_range(9)));
                    endcase
                end
                rx_q.push_back(8'h0A);
                run_int($urandom, 1'b0, $sformatf("rnd_int%0d", t));
            end else begin
                rx_q.delete();
                n = $urandom_range(10);
                for (int i = 0; i < n; i++) rx_q.push_back(8'($urandom_range(8'h7E, 8'h20)));
                rx_q.push_back(8'h0A);
                a = $urandom;
                case ($urandom_range(5))
                    0:       l = 32'd0;
                    1:       l = 32'd1;
                    2:       l = 32'h80000005;
                    default: l = 32'($urandom_range(14, 2));
                endcase
                run_str(a, l, $sformatf("rnd_str%0d", t));
            end
            idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
